// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
// The top level derives its parameter defaults from here.
package clk_div_pkg;

    localparam int DIV_W_PKG        = 27;
    localparam int DEFAULT_HALF_PKG = 2;

    typedef logic [DIV_W_PKG-1:0] half_t;

    // Channel-select width: max(1, clog2(n)).
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, 50% duty output, rise strobe,
// and a staged half-period that is applied only at a safe boundary.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W        = DIV_W_PKG,
    parameter int DEFAULT_HALF = DEFAULT_HALF_PKG
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             sync,
    input  logic             accept,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] half_reg, half_next;
    logic [DIV_W-1:0] staged_reg, staged_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic             pending_reg, pending_next;

    logic [DIV_W-1:0] half_eff;
    logic             terminal;
    logic             commit;

    // A stored half-period of zero runs as one.
    assign half_eff = (half_reg == '0) ? DIV_W'(1) : half_reg;
    assign terminal = (cnt_reg == half_eff - DIV_W'(1));
    assign commit   = pending_reg && (sync || !en || (terminal && clk_out_reg));

    always_comb begin
        cnt_next     = cnt_reg;
        half_next    = half_reg;
        staged_next  = staged_reg;
        clk_out_next = clk_out_reg;
        tick_next    = 1'b0;
        pending_next = pending_reg;

        if (sync || !en) begin
            cnt_next     = '0;
            clk_out_next = 1'b0;
        end else if (terminal) begin
            cnt_next     = '0;
            clk_out_next = ~clk_out_reg;
            tick_next    = ~clk_out_reg;
        end else begin
            cnt_next = cnt_reg + DIV_W'(1);
        end

        if (commit) begin
            half_next    = staged_reg;
            pending_next = 1'b0;
        end
        // Accept is only possible while nothing is pending, so it never
        // collides with a commit on this channel.
        if (accept) begin
            staged_next  = cfg_half;
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg     <= '0;
            half_reg    <= DIV_W'(DEFAULT_HALF);
            staged_reg  <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            half_reg    <= half_next;
            staged_reg  <= staged_next;
            clk_out_reg <= clk_out_next;
            tick_reg    <= tick_next;
            pending_reg <= pending_next;
        end
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;
    assign pending = pending_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider top: config decode, ready mux and sync fan-out
// around N_CH independent divider channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DIV_W        = DIV_W_PKG,
    parameter int DEFAULT_HALF = DEFAULT_HALF_PKG,
    parameter int CH_W         = ch_width(N_CH)
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_half,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    localparam int N_SEL = 2 ** CH_W;

    // Unused select codes read as not pending, so requests to them are
    // accepted and silently dropped.
    logic [N_SEL-1:0] pending_pad;
    logic [N_CH-1:0]  accept;

    generate
        for (genvar gi = 0; gi < N_SEL; gi++) begin : g_sel
            if (gi < N_CH) begin : g_ch
                assign accept[gi]      = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));
                assign pending_pad[gi] = pending[gi];

                clk_div_channel #(
                    .DIV_W        (DIV_W),
                    .DEFAULT_HALF (DEFAULT_HALF)
                ) u_channel (
                    .clk      (sysclk),
                    .srst     (reset),
                    .en       (ch_en[gi]),
                    .sync     (sync),
                    .accept   (accept[gi]),
                    .cfg_half (cfg_half),
                    .clk_out  (clk_out[gi]),
                    .tick     (tick[gi]),
                    .pending  (pending[gi])
                );
            end else begin : g_pad
                assign pending_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign cfg_ready = ~pending_pad[cfg_ch];

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboarded directed bench for clk_div_multi: stimulus queues expected
// per-cycle output values, a negedge monitor pops and compares them.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic            sysclk;
    logic            reset;
    logic [N_CH-1:0] ch_en;
    logic            sync;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    half_t           cfg_half;
    logic [N_CH-1:0] clk_out;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] pending;

    clk_div_multi #(
        .N_CH         (N_CH),
        .DIV_W        (DIV_W_PKG),
        .DEFAULT_HALF (DEFAULT_HALF_PKG),
        .CH_W         (CH_W)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // sel: 0 clk_out, 1 tick, 2 pending, 3 cfg_ready (bit 0)
    typedef struct {
        int         cyc;
        string      name;
        int         sel;
        logic [3:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   base   = 0;

    task automatic exp_at(input int rel, input string nm, input int sel, input logic [3:0] v);
        exp_t e;
        int   i;
        e.cyc  = base + rel;
        e.name = nm;
        e.sel  = sel;
        e.val  = v;
        i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endtask

    exp_t       mon_e;
    logic [3:0] mon_act;

    always @(negedge sysclk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            case (mon_e.sel)
                0:       mon_act = clk_out;
                1:       mon_act = tick;
                2:       mon_act = pending;
                default: mon_act = {3'b000, cfg_ready};
            endcase
            checks++;
            if (mon_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s missed at cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s cycle %0d actual %b required %b", mon_e.name, cyc, mon_act, mon_e.val);
            end else begin
                $display("ok   %s cycle %0d value %b", mon_e.name, cyc, mon_act);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ch_en     = '0;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_half  = '0;
        step(1);
        base = cyc;
        exp_at(0, "rst_clk", 0, 4'b0000);
        exp_at(0, "rst_tick", 1, 4'b0000);
        exp_at(0, "rst_pend", 2, 4'b0000);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: default rate, clk toggles every 2, tick every 4
        do_reset();
        ch_en = 4'b0001;
        exp_at(1, "t1_clk_lo", 0, 4'b0000);
        exp_at(2, "t1_clk_rise", 0, 4'b0001);
        exp_at(2, "t1_tick", 1, 4'b0001);
        exp_at(2, "t1_pend", 2, 4'b0000);
        exp_at(3, "t1_tick_off", 1, 4'b0000);
        exp_at(4, "t1_clk_fall", 0, 4'b0000);
        exp_at(6, "t1_clk_rise2", 0, 4'b0001);
        exp_at(6, "t1_tick2", 1, 4'b0001);
        step(8);

        // 2: reprogram ch1 to 5 mid-period
        do_reset();
        ch_en = 4'b0011;
        exp_at(1, "t2_ready_ch1_idle", 3, 4'b0001);
        exp_at(2, "t2_pend_set", 2, 4'b0010);
        exp_at(2, "t2_ready_ch1_busy", 3, 4'b0000);
        exp_at(3, "t2_ready_ch0", 3, 4'b0001);
        exp_at(4, "t2_commit_clk", 0, 4'b0000);
        exp_at(4, "t2_commit_pend", 2, 4'b0000);
        exp_at(8, "t2_no_runt", 0, 4'b0000);
        exp_at(9, "t2_rise5", 0, 4'b0010);
        exp_at(9, "t2_tick5", 1, 4'b0010);
        exp_at(13, "t2_high5", 0, 4'b0010);
        exp_at(14, "t2_fall5", 0, 4'b0001);
        exp_at(14, "t2_tick_ch0", 1, 4'b0001);
        exp_at(19, "t2_rise5b", 0, 4'b0011);
        exp_at(19, "t2_tick5b", 1, 4'b0010);
        step(1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_half  = half_t'(5);
        step(1);
        cfg_valid = 1'b0;
        step(1);
        cfg_ch = 2'd0;
        step(17);

        // 3: half=0 runs as half=1
        do_reset();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_half  = half_t'(0);
        exp_at(1, "t3_pend", 2, 4'b0001);
        exp_at(2, "t3_commit_dis", 2, 4'b0000);
        exp_at(3, "t3_clk_rise", 0, 4'b0001);
        exp_at(3, "t3_tick", 1, 4'b0001);
        exp_at(4, "t3_clk_fall", 0, 4'b0000);
        exp_at(4, "t3_tick_off", 1, 4'b0000);
        exp_at(5, "t3_clk_rise2", 0, 4'b0001);
        exp_at(5, "t3_tick2", 1, 4'b0001);
        step(1);
        cfg_valid = 1'b0;
        step(1);
        ch_en = 4'b0001;
        step(5);

        // 4: disable ch2 mid-period commits the staged value
        do_reset();
        ch_en = 4'b0100;
        exp_at(3, "t4_clk_high", 0, 4'b0100);
        exp_at(3, "t4_pend", 2, 4'b0100);
        exp_at(4, "t4_dis_clk", 0, 4'b0000);
        exp_at(4, "t4_dis_pend", 2, 4'b0000);
        exp_at(7, "t4_clk_lo", 0, 4'b0000);
        exp_at(8, "t4_rise3", 0, 4'b0100);
        exp_at(8, "t4_tick3", 1, 4'b0100);
        exp_at(10, "t4_high3", 0, 4'b0100);
        exp_at(11, "t4_fall3", 0, 4'b0000);
        exp_at(14, "t4_tick3b", 1, 4'b0100);
        step(2);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_half  = half_t'(3);
        step(1);
        cfg_valid = 1'b0;
        ch_en     = 4'b0000;
        step(2);
        ch_en = 4'b0100;
        step(10);

        // 5: half 3 and 7 out of phase, then sync
        do_reset();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_half  = half_t'(3);
        exp_at(12, "t5_pre_clk", 0, 4'b0011);
        exp_at(12, "t5_pre_pend", 2, 4'b0001);
        exp_at(13, "t5_sync_clk", 0, 4'b0000);
        exp_at(13, "t5_sync_tick", 1, 4'b0000);
        exp_at(13, "t5_sync_pend", 2, 4'b0000);
        exp_at(16, "t5_rise3", 0, 4'b0001);
        exp_at(16, "t5_tick3", 1, 4'b0001);
        exp_at(19, "t5_fall3", 0, 4'b0000);
        exp_at(20, "t5_rise7", 0, 4'b0010);
        exp_at(20, "t5_tick7", 1, 4'b0010);
        exp_at(22, "t5_both", 0, 4'b0011);
        exp_at(22, "t5_tick3b", 1, 4'b0001);
        step(1);
        cfg_ch   = 2'd1;
        cfg_half = half_t'(7);
        step(1);
        cfg_valid = 1'b0;
        step(1);
        ch_en = 4'b0001;
        step(1);
        ch_en = 4'b0011;
        step(7);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_half  = half_t'(3);
        step(1);
        cfg_valid = 1'b0;
        sync      = 1'b1;
        step(1);
        sync = 1'b0;
        step(10);

        // 6: reset mid-period discards the staged value
        do_reset();
        ch_en = 4'b0001;
        exp_at(3, "t6_clk_high", 0, 4'b0001);
        exp_at(3, "t6_pend", 2, 4'b0001);
        exp_at(4, "t6_rst_clk", 0, 4'b0000);
        exp_at(4, "t6_rst_tick", 1, 4'b0000);
        exp_at(4, "t6_rst_pend", 2, 4'b0000);
        exp_at(6, "t6_rise_dflt", 0, 4'b0001);
        exp_at(6, "t6_tick_dflt", 1, 4'b0001);
        exp_at(8, "t6_fall_dflt", 0, 4'b0000);
        exp_at(8, "t6_pend_clr", 2, 4'b0000);
        step(2);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_half  = half_t'(6);
        step(1);
        cfg_valid = 1'b0;
        reset     = 1'b1;
        step(1);
        reset = 1'b0;
        step(6);

        step(2);
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never compared (cycle %0d)", mon_e.name, mon_e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
